final385_soc_leds_pio: RTL and testbench
========================================

Name: final385_soc_leds_pio

Overview:
- Avalon-MM write-capable output PIO slave that drives board LEDs from the Nios II.
- It is the output-direction counterpart of the switch input PIO and uses the same bus protocol:
  - 2-bit word address.
  - Registered 32-bit readdata with one-cycle latency.
- Adds atomic set/clear registers and a hardware blink engine, so software can flash LEDs without polling a timer.
- Sits on the SoC's Avalon bus next to the switch and key PIOs; out_port goes to top-level LED pins.

Parameters:
- WIDTH, 8, number of output bits (1..32).
- RESET_VALUE, 0, value of the DATA register after reset.
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2); 0.5 s at 50 MHz.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- address  in  2  word address: 0 DATA, 1 BLINK_MASK, 2 OUTSET, 3 OUTCLEAR.
- chipselect  in  1  slave select; writes are ignored when low.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; only bits [WIDTH-1:0] are used.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- out_port  out  WIDTH  LED drive.

Behaviour:
- Reset (reset_n==0 at a clk edge):
  - data_reg=RESET_VALUE, blink_mask=0, prescaler=0, phase=0, readdata=0.
  - out_port therefore equals RESET_VALUE on the cycle after reset.
  - Reset asserted mid-blink aborts immediately; no partial toggle.
- Write accepted when chipselect==1 && write_n==0 at a clk edge; zero wait states.
  - addr 0: data_reg <= writedata[WIDTH-1:0].
  - addr 1: blink_mask <= writedata[WIDTH-1:0]; same edge forces prescaler<=0 and phase<=0, restarting the blink from "steady" phase.
  - addr 2: data_reg <= data_reg | writedata[WIDTH-1:0].
  - addr 3: data_reg <= data_reg & ~writedata[WIDTH-1:0].
- Readback:
  - Every clk edge (no read strobe, no chipselect qualification): readdata <= zero-extended mux(address).
    - addr 0 gives data_reg; addr 1 gives blink_mask; addr 2 and 3 give 0.
  - Latency: value reflects register state before any same-edge write. A read issued the cycle after a write returns the new value.
- Blink engine:
  - prescaler counts 0..BLINK_DIV-1, then wraps to 0.
  - On the wrap edge phase toggles.
  - prescaler runs continuously out of reset, including when blink_mask==0.
- Output: out_port = data_reg ^ (blink_mask & {WIDTH{phase}}), combinational from registers (glitch-free: all sources are flops).
  - Bits with mask=0 follow data_reg exactly; bits with mask=1 alternate data/~data every BLINK_DIV cycles.
- Boundaries:
  - BLINK_MASK write on the same edge as a prescaler wrap: the restart wins; phase=0, prescaler=0.
  - OUTSET/OUTCLEAR with writedata=0: no change.
  - writedata bits above WIDTH are ignored.
  - Writes with chipselect==0 have no effect.

Optional Feature:
- Macro LEDS_PIO_BLINK_EN.
- Defined: blink engine, BLINK_MASK register and prescaler present as above.
- Undefined:
  - No prescaler/phase/blink_mask flops.
  - addr 1 writes ignored; addr 1 reads return 0.
  - out_port = data_reg.
  - BLINK_DIV unused.

Decomposition:
- Shared package final385_soc_pio_pkg: register address constants (PIO_ADDR_DATA=0, PIO_ADDR_BLINK=1, PIO_ADDR_OUTSET=2, PIO_ADDR_OUTCLR=3) and the 32-bit Avalon data width constant.
  - The switch PIO side of the codebase reuses the same constants.
- One natural sub-module: final385_soc_blink_prescaler.
  - Parameter BLINK_DIV; inputs clk, reset_n, restart; output phase.
  - Instantiated only under LEDS_PIO_BLINK_EN.

Test Plan (WIDTH=8, RESET_VALUE=8'hA5, BLINK_DIV=4):
1. Reset: hold reset_n=0 two cycles, release.
   - out_port==8'hA5 and readdata==0.
   - With address=0, readdata==32'h000000A5 one cycle later.
2. Write DATA 32'hFFFF_FF3C.
   - out_port==8'h3C next cycle; readback 32'h0000003C.
   - Then the same write with chipselect=0 changes nothing.
3. OUTSET 8'h03, then OUTCLEAR 8'h30, from DATA=8'h3C.
   - out_port 8'h3F, then 8'h0F.
   - Reads at addr 2/3 return 0.
4. BLINK_MASK 8'h81 with DATA=8'h0F (macro defined).
   - out_port==8'h0F for 4 cycles, 8'h8E for 4, 8'h0F for 4, repeating.
   - Rewriting the mask mid-half-period restarts with 4 steady cycles.
5. Assert reset_n=0 for one cycle mid-blink.
   - Next cycle out_port==8'hA5 and the blink mask reads 0.
   - An asynchronous low pulse between edges has no effect.
6. Macro undefined: write addr 1 = 8'hFF.
   - Readback 0; out_port stays equal to DATA for 20 cycles.

Source files
------------

// File: rtl/final385_soc_pio_pkg.sv
// Register map and bus-width constants shared by the LED and switch PIO slaves.
package final385_soc_pio_pkg;

  localparam int PIO_DATA_W = 32;

  typedef logic [PIO_DATA_W-1:0] pio_word_t;
  typedef logic [1:0]            pio_addr_t;

  localparam pio_addr_t PIO_ADDR_DATA   = 2'd0;
  localparam pio_addr_t PIO_ADDR_BLINK  = 2'd1;
  localparam pio_addr_t PIO_ADDR_OUTSET = 2'd2;
  localparam pio_addr_t PIO_ADDR_OUTCLR = 2'd3;

endpackage

// File: rtl/final385_soc_blink_prescaler.sv
// Free-running half-period divider for the LED blink engine; phase toggles every BLINK_DIV clocks.
module final385_soc_blink_prescaler #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic phase
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // A restart coinciding with a wrap wins, so software always sees a full steady half-period.
  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/final385_soc_leds_pio.sv
// Avalon-MM LED output PIO with set/clear aliases and optional hardware blink.
// Define LEDS_PIO_BLINK_EN to build the BLINK_MASK register and blink prescaler.
module final385_soc_leds_pio
  import final385_soc_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [PIO_DATA_W-1:0] writedata,
  output logic [PIO_DATA_W-1:0] readdata,
  output logic [WIDTH-1:0]      out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_reg;
  pio_word_t        rd_next;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        PIO_ADDR_DATA:   data_reg <= wdata;
        PIO_ADDR_OUTSET: data_reg <= data_reg | wdata;
        PIO_ADDR_OUTCLR: data_reg <= data_reg & ~wdata;
        default:         data_reg <= data_reg;
      endcase
    end
  end

`ifdef LEDS_PIO_BLINK_EN
  logic [WIDTH-1:0] blink_mask;
  logic             restart;
  logic             phase;

  assign restart = wr_en && (address == PIO_ADDR_BLINK);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_mask <= '0;
    end else if (restart) begin
      blink_mask <= wdata;
    end
  end

  final385_soc_blink_prescaler #(
    .BLINK_DIV (BLINK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .phase   (phase)
  );

  assign out_port = data_reg ^ (blink_mask & {WIDTH{phase}});
`else
  localparam int unused_blink_div = BLINK_DIV;

  assign out_port = data_reg;
`endif

  // Read mux is unqualified: readdata tracks address every cycle with one clock of latency.
  always_comb begin
    rd_next = '0;
    case (address)
      PIO_ADDR_DATA:  rd_next[WIDTH-1:0] = data_reg;
`ifdef LEDS_PIO_BLINK_EN
      PIO_ADDR_BLINK: rd_next[WIDTH-1:0] = blink_mask;
`endif
      default:        rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_final385_soc_leds_pio.sv
// Scoreboard bench for final385_soc_leds_pio (WIDTH=8, RESET_VALUE=8'hA5, BLINK_DIV=4).
module tb_final385_soc_leds_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  final385_soc_leds_pio #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .BLINK_DIV   (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [7:0]  out;
    logic [31:0] rd;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] out, input logic [31:0] rd, input bit chk_rd);
    exp_t e;
    e.tag = tag; e.out = out; e.rd = rd; e.chk_rd = chk_rd;
    sb.push_back(e);
  endtask

  // Advance one edge, then retire every expectation queued for this sample.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".out"}, {24'h0, out_port}, {24'h0, e.out});
      if (e.chk_rd) check({e.tag, ".rd"}, readdata, e.rd);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
  endtask

  task automatic idle(input logic [1:0] a);
    drive(a, 1'b0, 1'b1, 32'h0);
  endtask

  function automatic logic [7:0] blink_exp(input int i);
    return ((i / 4) % 2 == 1) ? 8'h8E : 8'h0F;
  endfunction

  initial begin
    reset_n = 1'b0;
    idle(2'd0);

    // 1. reset
    push("rst0", 8'hA5, 32'h0, 1'b1); tick();
    push("rst1", 8'hA5, 32'h0, 1'b1); tick();
    reset_n = 1'b1;
    push("rst_rd", 8'hA5, 32'h0000_00A5, 1'b1); tick();

    // 2. DATA write, then chipselect-gated writes
    drive(2'd0, 1'b1, 1'b0, 32'hFFFF_FF3C);
    push("data_wr", 8'h3C, 32'h0000_00A5, 1'b1); tick();
    idle(2'd0);
    push("data_rd", 8'h3C, 32'h0000_003C, 1'b1); tick();
    drive(2'd0, 1'b0, 1'b0, 32'hFFFF_FF3C);
    push("cs0_same", 8'h3C, 32'h0000_003C, 1'b1); tick();
    drive(2'd0, 1'b0, 1'b0, 32'h0000_0055);
    push("cs0_diff", 8'h3C, 32'h0000_003C, 1'b1); tick();

    // 3. OUTSET / OUTCLEAR
    drive(2'd2, 1'b1, 1'b0, 32'h0000_0003);
    push("outset", 8'h3F, 32'h0, 1'b1); tick();
    drive(2'd3, 1'b1, 1'b0, 32'h0000_0030);
    push("outclr", 8'h0F, 32'h0, 1'b1); tick();
    drive(2'd2, 1'b1, 1'b0, 32'h0);
    push("outset0", 8'h0F, 32'h0, 1'b1); tick();
    drive(2'd3, 1'b1, 1'b0, 32'h0);
    push("outclr0", 8'h0F, 32'h0, 1'b1); tick();
    drive(2'd3, 1'b1, 1'b0, 32'hFFFF_FF00);
    push("outclr_hi", 8'h0F, 32'h0, 1'b1); tick();
    idle(2'd0);
    push("data_rd2", 8'h0F, 32'h0000_000F, 1'b1); tick();

`ifdef LEDS_PIO_BLINK_EN
    // 4. blink engine
    for (int i = 0; i < 18; i++) begin
      if (i == 0) drive(2'd1, 1'b1, 1'b0, 32'h0000_0081);
      else idle(2'd1);
      push($sformatf("blink%0d", i), blink_exp(i), (i == 0) ? 32'h0 : 32'h0000_0081, 1'b1);
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      if (j == 0) drive(2'd1, 1'b1, 1'b0, 32'h0000_0081);
      else idle(2'd1);
      push($sformatf("restart%0d", j), blink_exp(j), 32'h0000_0081, 1'b1);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 0) drive(2'd1, 1'b1, 1'b0, 32'h0000_0081);
      else idle(2'd1);
      push($sformatf("wrap_restart%0d", k), blink_exp(k), 32'h0000_0081, 1'b1);
      tick();
    end
`else
    // 6. blink register absent
    drive(2'd1, 1'b1, 1'b0, 32'h0000_00FF);
    push("nomask_wr", 8'h0F, 32'h0, 1'b1); tick();
    for (int i = 0; i < 20; i++) begin
      idle(2'd1);
      push($sformatf("nomask%0d", i), 8'h0F, 32'h0, 1'b1);
      tick();
    end
`endif

    // 5. mid-operation reset and a glitch that misses every edge
    reset_n = 1'b0;
    idle(2'd1);
    push("midrst", 8'hA5, 32'h0, 1'b1); tick();
    reset_n = 1'b1;
    push("midrst_mask", 8'hA5, 32'h0, 1'b1); tick();
    drive(2'd0, 1'b1, 1'b0, 32'h0000_003C);
    push("pre_glitch", 8'h3C, 32'h0000_00A5, 1'b1); tick();
    idle(2'd0);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    push("glitch", 8'h3C, 32'h0000_003C, 1'b1); tick();
    push("glitch2", 8'h3C, 32'h0000_003C, 1'b1); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
